jk_mode_register: RTL
=====================

Name: jk_mode_register

Overview:
- Parametrised WIDTH-bit register built from per-bit JK flip-flops, with four operating modes: per-bit JK, count up, count down and parallel load.
- Successor to the single-bit JK flip-flop; serves as the general storage/counting element for sequential labs and datapaths in this codebase.
- Count modes are synchronous: every bit is clocked together, with J=K driven by toggle enables. Counting is modulo MODULUS.

Parameters:
WIDTH, 4, register width in bits (1..16)
MODULUS, 16, count-mode wrap value; legal range 2..2^WIDTH; an out-of-range value triggers an elaboration-time $error

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
en  input  1  operation enable; 0 = hold all state
mode  input  2  00 JK, 01 count up, 10 count down, 11 load
j  input  WIDTH  per-bit J (JK mode only)
k  input  WIDTH  per-bit K (JK mode only)
d  input  WIDTH  parallel load data (load mode only)
q  output  WIDTH  register state
qn  output  WIDTH  bitwise complement of q
tc  output  1  terminal count (combinational)
changed  output  1  one-cycle pulse when q changed value

Behaviour:
- Reset:
  - rst high forces q=0 and changed=0 immediately, regardless of clk.
  - qn therefore reads all ones.
  - Asserting rst mid-operation aborts the current operation; no partial update is kept.
- en=0: q holds and changed=0 on the next edge, in every mode.
- JK mode (00), evaluated per bit at the clock edge:
  - j=0, k=0: hold.
  - j=1, k=0: set.
  - j=0, k=1: clear.
  - j=1, k=1: toggle.
  - MODULUS is not applied; any WIDTH-bit value is reachable.
- Count up (01):
  - If q >= MODULUS-1, next q=0; otherwise q+1.
  - An out-of-range q (left from JK or load mode) therefore wraps to 0.
- Count down (10):
  - If q == 0 or q >= MODULUS, next q=MODULUS-1; otherwise q-1.
- Load (11): next q = d, unrestricted.
- Latency: one clock from the enabling edge to the new q. qn follows q combinationally.
- tc = en & ((mode==01 & q==MODULUS-1) | (mode==10 & q==0)). It is 0 in JK and load modes.
- changed:
  - Registered; high for exactly the one cycle after an edge at which q_next != q.
  - Load of an identical value, or JK hold, gives changed=0.
- Mode may change on any cycle. Only the mode value sampled at the edge matters; there is no internal state beyond q and changed.
- Count-mode implementation: per-bit toggle enables drive J=K of each jk_ff_bit. Wrap cases are forced through J/K set/clear. No behavioural adder is allowed in place of the JK cells.

Optional Feature:
- Macro: JK_SYNC_CLR_EN.
- When defined:
  - Adds input clr (1 bit).
  - clr=1 at a clock edge forces q=0 regardless of en and mode, with priority over all modes.
  - changed pulses if q was nonzero.
  - tc is forced to 0 while clr=1.
- When undefined: the clr port does not exist and behaviour is exactly as above.

Decomposition:
- Package jk_pkg holds:
  - mode constants MODE_JK=2'b00, MODE_UP=2'b01, MODE_DOWN=2'b10, MODE_LOAD=2'b11
  - a 2-bit mode typedef
- Sub-module jk_ff_bit: one JK cell with ports clk, rst, j, k, q. It has asynchronous active-high reset to 0, and is instantiated WIDTH times via generate.
- Top level holds the mode decode, the per-bit J/K generation, the tc logic and the changed register.

Test Plan:
- Async reset: run count-up to q=5, pulse rst between clock edges -> q=0 and changed=0 before the next edge. After reset: qn=4'hF and tc=0.
- JK per-bit, WIDTH=4: q=4'b0000; apply j=1010, k=0000 -> q=1010. Then apply j=0110, k=0011:
  - bit 3: j=0, k=0, hold (1).
  - bit 2: j=1, k=0, set (1).
  - bit 1: j=1, k=1, toggle (1 -> 0).
  - bit 0: j=0, k=1, clear (0).
  - Result: q=1100, with changed pulsing each cycle.
- Modulo count up, MODULUS=10: start from q=0, run 12 edges -> q sequence 1..9, 0, 1, 2. tc=1 only while q=9. Separately, load q=12 then count up -> q=0.
- Count down, MODULUS=10: load 1, count down -> 0, 9, 8. tc=1 while q=0. Separately, load 14 then count down -> 9.
- Enable/changed: en=0 for 3 cycles in count-up -> q frozen, changed=0. Load the current value -> changed=0. Load a different value -> changed high for exactly 1 cycle.
- With JK_SYNC_CLR_EN defined: count up to 7, assert clr with en=0 -> q=0 at the next edge and changed pulses once. With clr=1 and mode=01, q stays 0 and tc=0.

Source files
------------

// File: rtl/jk_pkg.sv
// Shared mode encoding for the JK mode register and its testbench.
package jk_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_JK   = 2'b00;
  localparam mode_t MODE_UP   = 2'b01;
  localparam mode_t MODE_DOWN = 2'b10;
  localparam mode_t MODE_LOAD = 2'b11;

endpackage

// File: rtl/jk_ff_bit.sv
// Single JK flip-flop cell with asynchronous active-high reset to 0.
module jk_ff_bit (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  logic r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= 1'b0;
    end else begin
      case ({j, k})
        2'b00:   r_q <= r_q;
        2'b10:   r_q <= 1'b1;
        2'b01:   r_q <= 1'b0;
        default: r_q <= ~r_q;
      endcase
    end
  end

  assign q = r_q;

endmodule

// File: rtl/jk_mode_register.sv
// WIDTH-bit register of JK cells with JK / count-up / count-down / load modes.
// Optional synchronous clear input enabled by defining JK_SYNC_CLR_EN.
module jk_mode_register
  import jk_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] d,
`ifdef JK_SYNC_CLR_EN
  input  logic             clr,
`endif
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             tc,
  output logic             changed
);

  generate
    if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
      $error("jk_mode_register: WIDTH %0d outside 1..16", WIDTH);
    end
    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
      $error("jk_mode_register: MODULUS %0d outside 2..2^WIDTH", MODULUS);
    end
  endgenerate

  localparam int               LP_LAST   = MODULUS - 1;
  localparam logic [WIDTH-1:0] LP_LAST_V = LP_LAST[WIDTH-1:0];
  localparam logic [WIDTH:0]   LP_MOD_V  = MODULUS[WIDTH:0];

  mode_t            w_mode;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH:0]   w_q_ext;
  logic [WIDTH-1:0] w_up_t;
  logic [WIDTH-1:0] w_dn_t;
  logic             w_up_wrap;
  logic             w_dn_wrap;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  logic [WIDTH-1:0] w_q_next;
  logic             w_clr;
  logic             r_changed;

  assign w_mode  = mode;
  assign w_q_ext = {1'b0, w_q};

`ifdef JK_SYNC_CLR_EN
  assign w_clr = clr;
`else
  assign w_clr = 1'b0;
`endif

  // Ripple toggle enables: a bit flips when all lower bits are 1 (up) or 0 (down).
  always_comb begin
    w_up_t    = '0;
    w_dn_t    = '0;
    w_up_t[0] = 1'b1;
    w_dn_t[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      w_up_t[i] = w_up_t[i-1] & w_q[i-1];
      w_dn_t[i] = w_dn_t[i-1] & ~w_q[i-1];
    end
  end

  assign w_up_wrap = (w_q_ext >= (LP_MOD_V - 1'b1));
  assign w_dn_wrap = (w_q == '0) || (w_q_ext >= LP_MOD_V);

  // Wrap targets are forced through set/clear rather than toggling.
  always_comb begin
    w_j = '0;
    w_k = '0;
    if (en) begin
      case (w_mode)
        MODE_JK: begin
          w_j = j;
          w_k = k;
        end
        MODE_UP: begin
          if (w_up_wrap) begin
            w_k = '1;
          end else begin
            w_j = w_up_t;
            w_k = w_up_t;
          end
        end
        MODE_DOWN: begin
          if (w_dn_wrap) begin
            w_j = LP_LAST_V;
            w_k = ~LP_LAST_V;
          end else begin
            w_j = w_dn_t;
            w_k = w_dn_t;
          end
        end
        MODE_LOAD: begin
          w_j = d;
          w_k = ~d;
        end
        default: begin
          w_j = '0;
          w_k = '0;
        end
      endcase
    end
    if (w_clr) begin
      w_j = '0;
      w_k = '1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      jk_ff_bit u_bit (
        .clk (clk),
        .rst (rst),
        .j   (w_j[gi]),
        .k   (w_k[gi]),
        .q   (w_q[gi])
      );
    end
  endgenerate

  // Next-state preview of the JK cells, used only to detect a change.
  assign w_q_next = (w_j & ~w_q) | (~w_k & w_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_changed <= 1'b0;
    end else begin
      r_changed <= (w_q_next != w_q);
    end
  end

  assign q       = w_q;
  assign qn      = ~w_q;
  assign changed = r_changed;
  assign tc      = en & ~w_clr &
                   (((w_mode == MODE_UP) & (w_q == LP_LAST_V)) |
                    ((w_mode == MODE_DOWN) & (w_q == '0)));

endmodule
